// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: a multi-cycle MULT/DIV sets busy and commits HI/LO when its counter expires.
// Define MDU_TRACE_EN to print every HI/LO commit as "time@pc: $hi/$lo <= value".
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, b_q, pc_q;
    logic [2:0]    op_q;
    logic [31:0]   hi_q, lo_q, hi_d, lo_d;
    logic          hi_we, lo_we;
    logic [31:0]   trace_pc;

    logic          accept, start_md, done;
    logic [63:0]   prod;
    logic          div_signed, neg_q, neg_r;
    logic [31:0]   abs_a, abs_b, den, q_mag, r_mag, quot, rem;

    // Acceptance uses the registered busy, so a start on the falling edge of busy waits one cycle.
    assign accept   = start && !busy;
    assign start_md = accept && !op[2];
    assign done     = (state_q == BUSY) && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_md) state_d = BUSY;
            BUSY: if (done)     state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == BUSY);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (start_md) cnt_d = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Signed multiply as a 64-bit product of sign-extended operands.
    assign prod = (op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q}) *
                  (op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q});

    // Signed divide on magnitudes; avoids the 0x80000000 / -1 overflow trap.
    assign div_signed = !op_q[0];
    assign abs_a      = (div_signed && a_q[31]) ? -a_q : a_q;
    assign abs_b      = (div_signed && b_q[31]) ? -b_q : b_q;
    assign den        = (abs_b == '0) ? 32'd1 : abs_b;
    assign q_mag      = abs_a / den;
    assign r_mag      = abs_a % den;
    assign neg_q      = div_signed && (a_q[31] ^ b_q[31]);
    assign neg_r      = div_signed && a_q[31];
    assign quot       = neg_q ? -q_mag : q_mag;
    assign rem        = neg_r ? -r_mag : r_mag;

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        trace_pc = pc_q;
        if (done) begin
            if (!op_q[1]) begin
                {hi_d, lo_d} = prod;
                hi_we        = 1'b1;
                lo_we        = 1'b1;
            end else if (b_q != '0) begin
                hi_d  = rem;
                lo_d  = quot;
                hi_we = 1'b1;
                lo_we = 1'b1;
            end
        end else if (accept && op == OP_MTHI) begin
            hi_d     = a;
            hi_we    = 1'b1;
            trace_pc = pc;
        end else if (accept && op == OP_MTLO) begin
            lo_d     = a;
            lo_we    = 1'b1;
            trace_pc = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (hi_we) hi_q <= hi_d;
            if (lo_we) lo_q <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && start_md) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            pc_q <= pc;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

`ifdef MDU_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (hi_we) $display("%d@%h: $hi <= %h", $time, trace_pc, hi_d);
            if (lo_we) $display("%d@%h: $lo <= %h", $time, trace_pc, lo_d);
        end
    end
`else
    logic unused_trace;
    assign unused_trace = ^trace_pc;
`endif

endmodule
